// File: rtl/div_sched_pkg.sv
// rtl/div_sched_pkg.sv - shared constants for the divider scheduler
// FSM encoding and response error codes used by div_sched.
package div_sched_pkg;

  localparam int DW_DEF = 16;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_DIV0 = 2'b01;
  localparam logic [1:0] ERR_OVF  = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter
// Grant is combinational; the remembered winner only moves on an accept.
module rr_arb2 (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [1:0] i_valid,
  input  logic       i_accept,
  output logic [1:0] o_grant,
  output logic       o_last_grant
);

  logic r_last_grant;

  assign o_last_grant = r_last_grant;

  always_comb begin
    o_grant = i_valid;
    if (i_valid == 2'b11) o_grant = r_last_grant ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)        r_last_grant <= 1'b1;
    else if (i_accept) r_last_grant <= o_grant[1];
  end

endmodule

// File: rtl/div_sched.sv
// rtl/div_sched.sv - shares one unsigned sequential divider between two requesters
// Adds signed division, divide-by-zero/overflow bypass and a hung-divider watchdog.
module div_sched
  import div_sched_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = 40
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [DW-1:0] req0_dividend,
  input  logic [DW-1:0] req0_divisor,
  input  logic          req0_signed,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [DW-1:0] req1_dividend,
  input  logic [DW-1:0] req1_divisor,
  input  logic          req1_signed,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [DW-1:0] rsp_quotient,
  output logic [DW-1:0] rsp_remain,
  output logic [1:0]    rsp_err,
  output logic          div_start,
  output logic [DW-1:0] div_q,
  output logic [DW-1:0] div_m,
  input  logic [DW-1:0] div_quotient,
  input  logic [DW-1:0] div_remain,
  input  logic          div_done
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LP_CNT_MAX = CW'(TIMEOUT - 1);
  localparam logic [DW-1:0] LP_MIN_NEG = {1'b1, {(DW-1){1'b0}}};

  logic [2:0]    r_state;
  logic          r_id;
  logic          r_sgn;
  logic          r_dvd_neg;
  logic          r_dvs_neg;
  logic [DW-1:0] r_q;
  logic [DW-1:0] r_m;
  logic [DW-1:0] r_quo;
  logic [DW-1:0] r_rem;
  logic [1:0]    r_err;
  logic [CW-1:0] r_cnt;

  logic [1:0]    w_grant;
  logic          w_last_grant;
  logic          w_accept;
  logic          w_sel;
  logic [DW-1:0] w_dvd;
  logic [DW-1:0] w_dvs;
  logic          w_sgn;
  logic          w_dvd_neg;
  logic          w_dvs_neg;

  rr_arb2 u_arb (
    .clk          (clk),
    .n_rst        (n_rst),
    .i_valid      ({req1_valid, req0_valid}),
    .i_accept     (w_accept),
    .o_grant      (w_grant),
    .o_last_grant (w_last_grant)
  );

  assign req0_ready = (r_state == S_IDLE) && w_grant[0];
  assign req1_ready = (r_state == S_IDLE) && w_grant[1];
  assign w_accept   = req0_ready || req1_ready;

  assign w_sel     = w_grant[1];
  assign w_dvd     = w_sel ? req1_dividend : req0_dividend;
  assign w_dvs     = w_sel ? req1_divisor  : req0_divisor;
  assign w_sgn     = w_sel ? req1_signed   : req0_signed;
  assign w_dvd_neg = w_sgn && w_dvd[DW-1];
  assign w_dvs_neg = w_sgn && w_dvs[DW-1];

  assign div_start    = (r_state == S_LOAD);
  assign div_q        = r_q;
  assign div_m        = r_m;
  assign rsp_valid    = (r_state == S_RESP);
  assign rsp_id       = r_id;
  assign rsp_quotient = r_quo;
  assign rsp_remain   = r_rem;
  assign rsp_err      = r_err;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state   <= S_IDLE;
      r_id      <= 1'b0;
      r_sgn     <= 1'b0;
      r_dvd_neg <= 1'b0;
      r_dvs_neg <= 1'b0;
      r_q       <= '0;
      r_m       <= '0;
      r_quo     <= '0;
      r_rem     <= '0;
      r_err     <= ERR_OK;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_id      <= w_sel;
          r_sgn     <= w_sgn;
          r_dvd_neg <= w_dvd_neg;
          r_dvs_neg <= w_dvs_neg;
          r_q       <= w_dvd_neg ? -w_dvd : w_dvd;
          r_m       <= w_dvs_neg ? -w_dvs : w_dvs;
          if (w_dvs == '0) begin
            r_quo   <= '1;
            r_rem   <= w_dvd;
            r_err   <= ERR_DIV0;
            r_state <= S_RESP;
          end else if (w_sgn && (w_dvd == LP_MIN_NEG) && (w_dvs == '1)) begin
            // most-negative / -1 has no representable positive quotient
            r_quo   <= LP_MIN_NEG;
            r_rem   <= '0;
            r_err   <= ERR_OVF;
            r_state <= S_RESP;
          end else begin
            r_err   <= ERR_OK;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (div_done) begin
            r_quo   <= div_quotient;
            r_rem   <= div_remain;
            r_state <= S_FIX;
          end else if (r_cnt == LP_CNT_MAX) begin
            r_quo   <= '0;
            r_rem   <= '0;
            r_err   <= ERR_TMO;
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_FIX: begin
          if (r_sgn && (r_dvd_neg ^ r_dvs_neg)) r_quo <= -r_quo;
          if (r_sgn && r_dvd_neg)               r_rem <= -r_rem;
          r_state <= S_RESP;
        end
        S_RESP: if (rsp_ready) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sched.sv
// tb/tb_div_sched.sv - self-checking bench for div_sched
// Behavioural divider with selectable latency or hang, plus a response model.
module tb_div_sched;

  localparam int DW  = 16;
  localparam int TMO = 40;

  typedef struct {
    logic        id;
    logic [15:0] q;
    logic [15:0] r;
    logic [1:0]  err;
  } rsp_t;

  logic clk = 1'b0;
  logic n_rst = 1'b1;
  logic req0_valid = 0, req1_valid = 0, req0_signed = 0, req1_signed = 0;
  logic [DW-1:0] req0_dividend = 0, req0_divisor = 0, req1_dividend = 0, req1_divisor = 0;
  logic req0_ready, req1_ready;
  logic rsp_valid, rsp_id, div_start;
  logic rsp_ready = 0;
  logic [DW-1:0] rsp_quotient, rsp_remain, div_q, div_m;
  logic [1:0] rsp_err;
  logic [DW-1:0] div_quotient, div_remain;
  logic div_done;

  always #5 clk = ~clk;

  div_sched #(.DW(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .n_rst(n_rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_dividend(req0_dividend),
    .req0_divisor(req0_divisor), .req0_signed(req0_signed),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_dividend(req1_dividend),
    .req1_divisor(req1_divisor), .req1_signed(req1_signed),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_quotient(rsp_quotient), .rsp_remain(rsp_remain), .rsp_err(rsp_err),
    .div_start(div_start), .div_q(div_q), .div_m(div_m),
    .div_quotient(div_quotient), .div_remain(div_remain), .div_done(div_done)
  );

  // behavioural unsigned divider; when hang is set it accepts start but never finishes
  int  lat = 3;
  bit  hang = 0;
  logic [15:0] d_a, d_b;
  int  d_cnt;
  logic d_busy;
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      d_busy <= 0; div_done <= 0; div_quotient <= 0; div_remain <= 0; d_cnt <= 0;
      d_a <= 0; d_b <= 1;
    end else begin
      div_done <= 0;
      if (div_start) begin
        d_a <= div_q; d_b <= div_m; d_cnt <= lat; d_busy <= !hang;
      end else if (d_busy) begin
        if (d_cnt <= 1) begin
          div_quotient <= d_a / d_b; div_remain <= d_a % d_b;
          div_done <= 1; d_busy <= 0;
        end else d_cnt <= d_cnt - 1;
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_err = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic rsp_t model(logic id, logic [15:0] a, logic [15:0] b, logic s, bit hg);
    rsp_t e;
    int sa, sb;
    e.id = id;
    if (b == 0) begin
      e.q = 16'hFFFF; e.r = a; e.err = 2'd1;
    end else if (s && a == 16'h8000 && b == 16'hFFFF) begin
      e.q = 16'h8000; e.r = 0; e.err = 2'd2;
    end else if (hg) begin
      e.q = 0; e.r = 0; e.err = 2'd3;
    end else if (s) begin
      sa = int'($signed(a)); sb = int'($signed(b));
      e.q = 16'(sa / sb); e.r = 16'(sa % sb); e.err = 2'd0;
    end else begin
      e.q = a / b; e.r = a % b; e.err = 2'd0;
    end
    return e;
  endfunction

  rsp_t exp_q[$];
  int n_start = 0, t_acc = 0, t_start = 0, t_done = 0, t_rsp = 0;
  logic [15:0] st_q = 0, st_m = 0;
  logic prev_valid = 0;

  always @(negedge clk) begin
    if (!n_rst) begin
      exp_q.delete();
      prev_valid = 0;
    end else begin
      chk("one_ready", 32'(req0_ready & req1_ready), 32'h0);
      if (div_start) begin n_start++; t_start = cyc; st_q = div_q; st_m = div_m; end
      if (div_done) t_done = cyc;
      if (rsp_valid) begin
        if (!prev_valid) t_rsp = cyc;
        chk("ready_in_resp", 32'({req0_ready, req1_ready}), 32'h0);
        if (exp_q.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 required 0 (cycle %0d)", cyc);
        end else begin
          chk("rsp_id", 32'(rsp_id), 32'(exp_q[0].id));
          chk("rsp_q", 32'(rsp_quotient), 32'(exp_q[0].q));
          chk("rsp_r", 32'(rsp_remain), 32'(exp_q[0].r));
          chk("rsp_err", 32'(rsp_err), 32'(exp_q[0].err));
          if (rsp_ready) void'(exp_q.pop_front());
        end
      end
      prev_valid = rsp_valid;
      if (req0_valid && req0_ready) begin
        exp_q.push_back(model(0, req0_dividend, req0_divisor, req0_signed, hang)); t_acc = cyc;
      end
      if (req1_valid && req1_ready) begin
        exp_q.push_back(model(1, req1_dividend, req1_divisor, req1_signed, hang)); t_acc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic arm(input int id, input logic [15:0] a, input logic [15:0] b, input logic s);
    if (id == 0) begin req0_dividend = a; req0_divisor = b; req0_signed = s; req0_valid = 1; end
    else begin req1_dividend = a; req1_divisor = b; req1_signed = s; req1_valid = 1; end
  endtask

  // waits for either ready; returns which requester was accepted, or -1 on timeout
  task automatic wait_accept(output int who);
    who = -1;
    for (int i = 0; i < 200 && who < 0; i++) begin
      @(negedge clk);
      if (req0_valid && req0_ready) who = 0;
      else if (req1_valid && req1_ready) who = 1;
    end
    if (who < 0) begin
      n_chk++; n_err++;
      $display("FAIL accept_timeout: got no ready required one within 200 cycles");
    end
    tick();
  endtask

  task automatic send(input int id, input logic [15:0] a, input logic [15:0] b, input logic s);
    int who;
    arm(id, a, b, s);
    wait_accept(who);
    if (id == 0) req0_valid = 0; else req1_valid = 0;
  endtask

  task automatic take(input int hold, output rsp_t g);
    bit seen = 0;
    g.id = 0; g.q = 0; g.r = 0; g.err = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = rsp_valid;
    end
    if (!seen) begin
      n_chk++; n_err++;
      $display("FAIL rsp_timeout: got no rsp_valid required one within 200 cycles");
      return;
    end
    g.id = rsp_id; g.q = rsp_quotient; g.r = rsp_remain; g.err = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 32'h1);
      chk("hold_q", 32'(rsp_quotient), 32'(g.q));
      chk("hold_r", 32'(rsp_remain), 32'(g.r));
      chk("hold_ready", 32'({req0_ready, req1_ready}), 32'h0);
    end
    tick();
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
  endtask

  task automatic chk_rsp(input string name, input rsp_t g, input logic id,
                         input logic [15:0] q, input logic [15:0] r, input logic [1:0] err);
    chk({name, "_id"}, 32'(g.id), 32'(id));
    chk({name, "_q"}, 32'(g.q), 32'(q));
    chk({name, "_r"}, 32'(g.r), 32'(r));
    chk({name, "_err"}, 32'(g.err), 32'(err));
  endtask

  rsp_t g;
  int s0, who, bad;
  int order[4];
  int served[2];

  initial begin
    #1 n_rst = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outs", 32'({rsp_valid, div_start, req0_ready, req1_ready, rsp_id, rsp_err}), 32'h0);
    chk("rst_data", 32'(rsp_quotient | rsp_remain | div_q | div_m), 32'h0);
    tick();
    n_rst = 1;
    tick();

    s0 = n_start;
    send(0, 16'd100, 16'd7, 0);
    take(0, g);
    chk_rsp("u100_7", g, 0, 16'd14, 16'd2, 2'b00);
    chk("u100_7_starts", 32'(n_start - s0), 32'd1);
    chk("u100_7_lat", 32'(t_rsp - t_done), 32'd2);

    send(1, 16'hFFF9, 16'h0002, 1);
    take(0, g);
    chk_rsp("sm7_2", g, 1, 16'hFFFD, 16'hFFFF, 2'b00);
    chk("sm7_2_divq", 32'(st_q), 32'd7);
    chk("sm7_2_divm", 32'(st_m), 32'd2);

    s0 = n_start;
    send(0, 16'h1234, 16'h0000, 0);
    take(0, g);
    chk_rsp("div0", g, 0, 16'hFFFF, 16'h1234, 2'b01);
    chk("div0_starts", 32'(n_start - s0), 32'd0);
    chk("div0_lat", 32'(t_rsp - t_acc), 32'd1);

    send(1, 16'h8000, 16'hFFFF, 1);
    take(0, g);
    chk_rsp("ovf", g, 1, 16'h8000, 16'h0000, 2'b10);
    chk("ovf_starts", 32'(n_start - s0), 32'd0);
    chk("ovf_lat", 32'(t_rsp - t_acc), 32'd1);

    send(0, 16'd20, 16'd6, 0);
    arm(1, 16'd9, 16'd4, 0);
    take(5, g);
    chk_rsp("hold", g, 0, 16'd3, 16'd2, 2'b00);
    send(1, 16'd9, 16'd4, 0);
    take(0, g);
    chk_rsp("after_hold", g, 1, 16'd2, 16'd1, 2'b00);

    hang = 1;
    send(0, 16'd500, 16'd3, 0);
    take(0, g);
    hang = 0;
    chk_rsp("tmo", g, 0, 16'd0, 16'd0, 2'b11);
    chk("tmo_lat", 32'(t_rsp - t_start), 32'(TMO + 1));

    lat = 20;
    s0 = n_start;
    send(1, 16'd77, 16'd5, 0);
    repeat (4) tick();
    chk("abort_started", 32'(n_start - s0), 32'd1);
    #2 n_rst = 0;
    #1;
    chk("abort_outs", 32'({rsp_valid, div_start, req0_ready, req1_ready, rsp_id, rsp_err}), 32'h0);
    chk("abort_data", 32'(rsp_quotient | rsp_remain | div_q | div_m), 32'h0);
    tick();
    n_rst = 1;
    lat = 3;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rsp_valid) bad++;
    end
    chk("abort_no_rsp", 32'(bad), 32'd0);
    tick();

    served[0] = 0; served[1] = 0;
    arm(0, 16'd1000, 16'd10, 0);
    arm(1, 16'hFFCE, 16'd7, 1);
    for (int k = 0; k < 4; k++) begin
      wait_accept(who);
      order[k] = who;
      if (who >= 0) begin
        served[who]++;
        if (who == 0) begin
          if (served[0] < 2) arm(0, 16'd50000, 16'd3, 0); else req0_valid = 0;
        end else begin
          if (served[1] < 2) arm(1, 16'd30, 16'hFFFB, 1); else req1_valid = 0;
        end
      end
      take(0, g);
      if (k == 1) chk_rsp("rr_sm50_7", g, 1, 16'hFFF9, 16'hFFFF, 2'b00);
      if (k == 3) chk_rsp("rr_30_m5", g, 1, 16'hFFFA, 16'h0000, 2'b00);
    end
    req0_valid = 0; req1_valid = 0;
    chk("rr_order0", 32'(order[0]), 32'd0);
    chk("rr_order1", 32'(order[1]), 32'd1);
    chk("rr_order2", 32'(order[2]), 32'd0);
    chk("rr_order3", 32'(order[3]), 32'd1);

    repeat (5) tick();
    chk("model_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
